dm_access_ctrl: RTL and testbench
=================================

// Module: dm_access_ctrl
// PURPOSE
//  - Initiator side of the byte-addressed data memory (dm_1k).
//  - Takes one CPU load/store request at a time and drives the memory's addr/din/we lines, reading dout.
//  - Supports byte, halfword and word accesses, signed or unsigned.
//  - Sub-word stores use read-modify-write on the aligned word, because the memory only writes whole 32-bit words.
// PARAMETERS
//  ADDR_W   10   memory byte-address width (memory depth = 2**ADDR_W bytes)
// PORTS
//  clk        in   1       clock; all state changes on posedge
//  rst_n      in   1       synchronous, active-low reset
//  req        in   1       request; sampled only in IDLE
//  we         in   1       1 = store, 0 = load
//  size       in   2       00 byte, 01 half, 10 word, 11 illegal
//  sign_ext   in   1       loads: 1 = sign-extend, 0 = zero-extend
//  addr       in   32      byte address
//  wdata      in   32      store data; low byte/half used for sub-word stores
//  busy       out  1       high in any state other than IDLE
//  done       out  1       one-cycle pulse in RESP
//  err        out  1       valid with done; 1 = request rejected
//  rdata      out  32      load result; held until the next successful load completes
//  dm_addr    out  ADDR_W  memory address; always word-aligned (low 2 bits = 0)
//  dm_din     out  32      memory write data
//  dm_we      out  1       memory write enable
//  dm_dout    in   32      memory read data; combinational, little-endian
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE; done, err, dm_we = 0; rdata = 0; captured request regs = 0.
//  - dm_we = (state==WRITE) && rst_n, so a reset asserted during WRITE suppresses that memory write.
//  - Error conditions, checked in IDLE:
//    - size==11;
//    - half with addr[0]!=0;
//    - word with addr[1:0]!=0;
//    - addr[31:ADDR_W]!=0.
//    On error: go to RESP with err=1. No memory write. rdata unchanged.
//  - IDLE: if req && !error, capture we/size/sign_ext/addr/wdata, then:
//    - load -> READ;
//    - word store -> WRITE;
//    - sub-word store -> READ.
//    If !req, stay in IDLE.
//  - READ: dm_addr = {addr[ADDR_W-1:2],2'b00}; latch dm_dout into rbuf at posedge.
//    - load -> RESP; rdata is updated from the dm_dout value at that edge.
//    - store -> WRITE.
//  - WRITE: dm_addr = aligned address; dm_din per store type; dm_we=1 -> RESP.
//  - RESP: done=1; err valid -> IDLE. req arriving in RESP is ignored; the CPU re-presents it in IDLE.
//  - Lane rules: lane = addr[1:0]; byte k occupies bits [8k+7:8k].
//    - Load byte: rbuf[8*lane+:8], extended per sign_ext.
//    - Load half: rbuf[8*lane+:16], extended per sign_ext.
//    - Store byte/half: rbuf with only the addressed lane(s) replaced by wdata[7:0] / wdata[15:0].
//    - Store word: dm_din = wdata.
//  - Latency (req seen in IDLE at edge T): done is high in the cycle after edge
//    - T+1 for an error;
//    - T+2 for a load or word store;
//    - T+3 for a sub-word store.
//  - Outside IDLE, req and all other CPU inputs are ignored; captured values are used.
//  - dm_addr = 0 in IDLE and RESP; dm_din = 0 whenever not in WRITE.
// TESTING
//  1. mem[0x10..0x13] = 0x80,0x7F,0x34,0x12.
//     - Load word @0x10 -> rdata=0x12347F80, done 2 cycles after req.
//     - lb @0x10 signed -> 0xFFFFFF80.
//     - lbu @0x10 -> 0x00000080.
//  2. sw 0xDEADBEEF @0x20, then sb 0x55 @0x22 -> word @0x20 = 0xDE55BEEF; sb done 3 cycles after req.
//  3. sh 0xA5A5 @0x22 over 0x11223344 -> word = 0xA5A53344; lh @0x22 signed -> 0xFFFFA5A5.
//  4. Misaligned or out-of-range requests -> err=1 one cycle after req; dm_we never high; memory unchanged.
//     - lh @0x21; sw @0x22; size=11; addr=0x400.
//  5. rst_n low on the WRITE cycle of sw 0x1 @0x30 -> mem @0x30 unchanged; next cycle state=IDLE, busy=0, done=0.
//  6. Toggle req every cycle during a sub-word store -> exactly one done per accepted request; busy high for 3 cycles.

Source files
------------

// File: rtl/dm_access_ctrl.sv
// Initiator side of the byte-addressed data memory: one CPU load/store at a
// time, byte/half/word, signed or unsigned. Sub-word stores read the aligned
// word first and write it back with only the addressed lane(s) replaced.
module dm_access_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_din,
  output logic              dm_we,
  input  logic [31:0]       dm_dout
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  state_t              state_reg, state_next;
  logic                we_reg;
  logic [1:0]          size_reg;
  logic                sext_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [31:0]         wdata_reg;
  logic [31:0]         rbuf_reg;
  logic [31:0]         rdata_reg;
  logic                err_reg;

  logic                req_error;
  logic [31:0]         load_value;
  logic [31:0]         store_word;
  logic [31:0]         shifted;

  // Reject illegal size, misalignment and addresses beyond the memory.
  always_comb begin
    req_error = (size == SZ_BAD)
              || ((size == SZ_HALF) && addr[0])
              || ((size == SZ_WORD) && (addr[1:0] != 2'b00))
              || (addr[31:ADDR_W] != '0);
  end

  // Extract and extend the addressed lane(s) from the word being read.
  always_comb begin
    shifted    = dm_dout >> {addr_reg[1:0], 3'b000};
    load_value = dm_dout;
    case (size_reg)
      SZ_BYTE: load_value = sext_reg ? {{24{shifted[7]}}, shifted[7:0]}
                                     : {24'h0, shifted[7:0]};
      SZ_HALF: load_value = sext_reg ? {{16{shifted[15]}}, shifted[15:0]}
                                     : {16'h0, shifted[15:0]};
      default: load_value = dm_dout;
    endcase
  end

  // Per-lane merge of store data into the previously read word.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    localparam bit         HI   = (gi >= 2);
    localparam bit         ODD  = (gi % 2) == 1;
    logic hit;
    always_comb begin
      hit = ((size_reg == SZ_BYTE) && (addr_reg[1:0] == LANE))
         || ((size_reg == SZ_HALF) && (addr_reg[1] == HI));
      if (size_reg == SZ_WORD)
        store_word[8*gi +: 8] = wdata_reg[8*gi +: 8];
      else if (hit && (size_reg == SZ_HALF) && ODD)
        store_word[8*gi +: 8] = wdata_reg[15:8];
      else if (hit)
        store_word[8*gi +: 8] = wdata_reg[7:0];
      else
        store_word[8*gi +: 8] = rbuf_reg[8*gi +: 8];
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req) begin
          if (req_error)             state_next = RESP;
          else if (!we)              state_next = READ;
          else if (size == SZ_WORD)  state_next = WRITE;
          else                       state_next = READ;
        end
      end
      READ:    state_next = we_reg ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, captured request and read-data registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      we_reg    <= 1'b0;
      size_reg  <= 2'b00;
      sext_reg  <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= 32'h0;
      rbuf_reg  <= 32'h0;
      rdata_reg <= 32'h0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == IDLE) && req) begin
        err_reg <= req_error;
        if (!req_error) begin
          we_reg    <= we;
          size_reg  <= size;
          sext_reg  <= sign_ext;
          addr_reg  <= addr[ADDR_W-1:0];
          wdata_reg <= wdata;
        end
      end
      if (state_reg == READ) begin
        rbuf_reg <= dm_dout;
        if (!we_reg) rdata_reg <= load_value;
      end
    end
  end

  // Outputs decoded from the current state; the write strobe also drops
  // immediately when reset is asserted so a reset during WRITE cancels it.
  always_comb begin
    busy    = (state_reg != IDLE);
    done    = (state_reg == RESP);
    err     = (state_reg == RESP) && err_reg;
    rdata   = rdata_reg;
    dm_we   = (state_reg == WRITE) && rst_n;
    dm_addr = '0;
    dm_din  = 32'h0;
    if ((state_reg == READ) || (state_reg == WRITE))
      dm_addr = {addr_reg[ADDR_W-1:2], 2'b00};
    if (state_reg == WRITE)
      dm_din = store_word;
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl with a byte-array memory model and a
// scoreboard of expected responses.
module tb_dm_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic [9:0]  dm_addr;
  logic [31:0] dm_din;
  logic        dm_we;
  logic [31:0] dm_dout;

  dm_access_ctrl #(.ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(busy),
    .done(done), .err(err), .rdata(rdata), .dm_addr(dm_addr),
    .dm_din(dm_din), .dm_we(dm_we), .dm_dout(dm_dout)
  );

  always #5 clk = ~clk;

  // Memory model: combinational little-endian read, whole-word write.
  logic [7:0]  mem [0:1023];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  assign dm_dout = {mem[{dm_addr[9:2], 2'd3}], mem[{dm_addr[9:2], 2'd2}],
                    mem[{dm_addr[9:2], 2'd1}], mem[{dm_addr[9:2], 2'd0}]};

  always @(posedge clk) begin
    if (pl_en) begin
      for (int i = 0; i < 4; i++) mem[{pl_addr[9:2], 2'(i)}] <= pl_data[8*i +: 8];
    end else if (dm_we) begin
      for (int i = 0; i < 4; i++) mem[{dm_addr[9:2], 2'(i)}] <= dm_din[8*i +: 8];
    end
  end

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_rdata = 32'h0;

  function automatic logic [31:0] memw(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issue one request, push its expectation, then wait for done and compare.
  task automatic do_req(input string tag, input logic w, input logic [1:0] sz,
                        input logic sx, input logic [31:0] a, input logic [31:0] d,
                        input logic exp_err, input logic [31:0] exp_rdata,
                        input int lat, input bit toggle);
    exp_t e;
    int   cyc = 0;
    int   busy_cnt = 0;
    int   extra = 0;
    bit   got = 0;
    bit   we_seen = 0;
    @(negedge clk);
    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
    e.err = exp_err; e.rdata = exp_rdata; e.lat = lat;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (!toggle) req = 1'b0;
    while (!got && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (busy)  busy_cnt++;
      if (dm_we) we_seen = 1;
      if (done) got = 1;
      else if (toggle) begin
        req = ~req; wdata = ~wdata; addr = addr ^ 32'h4;
      end
    end
    req = 1'b0;
    e = sb.pop_front();
    check({tag, "_done"}, 32'(got), 32'd1);
    if (got) begin
      check({tag, "_lat"},   32'(cyc), 32'(e.lat));
      check({tag, "_err"},   32'(err), 32'(e.err));
      check({tag, "_rdata"}, rdata, e.rdata);
      check({tag, "_busy"},  32'(busy_cnt), 32'(e.lat));
    end
    if (e.err) check({tag, "_no_we"}, 32'(we_seen), 32'd0);
    if (!e.err && !w) last_rdata = e.rdata;
    if (toggle) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (done) extra++;
      end
      check({tag, "_extra_done"}, 32'(extra), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
    addr = 32'h0; wdata = 32'h0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_busy",    32'(busy),  32'd0);
    check("rst_done",    32'(done),  32'd0);
    check("rst_err",     32'(err),   32'd0);
    check("rst_rdata",   rdata,      32'h0);
    check("rst_dm_we",   32'(dm_we), 32'd0);
    check("rst_dm_addr", 32'(dm_addr), 32'd0);
    check("rst_dm_din",  dm_din,     32'h0);
    rst_n = 1'b1;

    // Loads
    preload(10'h10, 32'h12347F80);
    do_req("lw10",  0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h12347F80, 2, 0);
    do_req("lb10",  0, 2'b00, 1, 32'h10, 32'h0, 0, 32'hFFFFFF80, 2, 0);
    do_req("lbu10", 0, 2'b00, 0, 32'h10, 32'h0, 0, 32'h00000080, 2, 0);
    do_req("lb11",  0, 2'b00, 1, 32'h11, 32'h0, 0, 32'h0000007F, 2, 0);
    do_req("lh10",  0, 2'b01, 1, 32'h10, 32'h0, 0, 32'h00007F80, 2, 0);
    do_req("lh12",  0, 2'b01, 1, 32'h12, 32'h0, 0, 32'h00001234, 2, 0);

    // Word store then byte read-modify-write
    do_req("sw20", 1, 2'b10, 0, 32'h20, 32'hDEADBEEF, 0, last_rdata, 2, 0);
    check("mem20_sw", memw(32'h20), 32'hDEADBEEF);
    do_req("sb22", 1, 2'b00, 0, 32'h22, 32'hFFFFFF55, 0, last_rdata, 3, 0);
    check("mem20_sb", memw(32'h20), 32'hDE55BEEF);
    do_req("lw20", 0, 2'b10, 0, 32'h20, 32'h0, 0, 32'hDE55BEEF, 2, 0);

    // Halfword store and signed halfword load
    preload(10'h20, 32'h11223344);
    do_req("sh22", 1, 2'b01, 0, 32'h22, 32'h0000A5A5, 0, last_rdata, 3, 0);
    check("mem20_sh", memw(32'h20), 32'hA5A53344);
    do_req("lh22", 0, 2'b01, 1, 32'h22, 32'h0, 0, 32'hFFFFA5A5, 2, 0);

    // Rejected requests
    do_req("e_lh21",  0, 2'b01, 1, 32'h21,  32'h0,        1, last_rdata, 1, 0);
    do_req("e_sw22",  1, 2'b10, 0, 32'h22,  32'h12345678, 1, last_rdata, 1, 0);
    do_req("e_sz11",  1, 2'b11, 0, 32'h20,  32'h12345678, 1, last_rdata, 1, 0);
    do_req("e_a400",  1, 2'b10, 0, 32'h400, 32'h12345678, 1, last_rdata, 1, 0);
    check("mem20_err", memw(32'h20), 32'hA5A53344);

    // Reset asserted during WRITE cancels the write
    preload(10'h30, 32'hCAFEF00D);
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h30; wdata = 32'h1;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    check("wr_dm_we", 32'(dm_we), 32'd1);
    rst_n = 1'b0;
    #1 check("rst_wr_dm_we", 32'(dm_we), 32'd0);
    @(negedge clk);
    check("rst_wr_busy",  32'(busy), 32'd0);
    check("rst_wr_done",  32'(done), 32'd0);
    check("rst_wr_rdata", rdata,     32'h0);
    rst_n = 1'b1;
    last_rdata = 32'h0;
    check("mem30_rst", memw(32'h30), 32'hCAFEF00D);

    // Sub-word store with req and data toggling while busy
    do_req("sb31_tog", 1, 2'b00, 0, 32'h31, 32'h00000077, 0, last_rdata, 3, 1);
    check("mem30_tog", memw(32'h30), 32'hCAFE770D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
